mdu: RTL and testbench

Iterative multiply/divide unit for the single-cycle processor datapath. It sits beside the ALU in the execute stage and takes the same two register operands. It produces a HI/LO result pair for the writeback result mux. Its 1-bit divide-by-zero flag feeds the 1-bit-to-32-bit zero extender so that software can read it as a word. A multi-cycle operation stalls the core through `busy`.

---
 rtl/mdu_if.sv | 18 +
 rtl/mdu.sv | 168 ++++++++++++++++
 tb/tb_mdu.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
// The master drives requests and operands; the slave (mdu) returns status and HI/LO.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;

    modport master (output start, op, a, b, input busy, done, hi, lo, dz);
    modport slave  (input start, op, a, b, output busy, done, hi, lo, dz);
endinterface

// File: rtl/mdu.sv
// Iterative multiply/divide: WIDTH cycles from the accepting edge to done; divide by zero finishes in one cycle.
// Backpressure: busy stalls the core; start is taken only in IDLE or DONE, ignored in RUN. Signed ops need MDU_SIGNED_EN.
module mdu #(
    parameter int WIDTH = 32
) (
    input logic   clk,
    input logic   reset,
    mdu_if.slave  mif
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] step;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // p_q holds {partial product, multiplier} for multiply, {remainder, dividend} for divide.
    always_comb begin
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : {WIDTH{1'b0}})};
        div_trial = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
        if (is_div_q) begin
            if (div_trial[WIDTH])
                step = {p_q[2*WIDTH-2:0], 1'b0};
            else
                step = {div_trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end else begin
            step = {mul_sum, p_q[WIDTH-1:1]};
        end
    end

`ifdef MDU_SIGNED_EN
    logic               a_neg, b_neg;
    logic               neg_q, neg_d, rneg_q, rneg_d;
    logic [2*WIDTH-1:0] prod_fix;

    assign a_neg = mif.op[0] & mif.a[WIDTH-1];
    assign b_neg = mif.op[0] & mif.b[WIDTH-1];
    assign mag_a = a_neg ? -mif.a : mif.a;
    assign mag_b = b_neg ? -mif.b : mif.b;

    always_comb begin
        neg_d  = neg_q;
        rneg_d = rneg_q;
        if (mif.start && (state_q != S_RUN)) begin
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
        end
    end

    // Quotient and product follow the sign XOR; the remainder follows the dividend.
    always_comb begin
        prod_fix = neg_q ? -step : step;
        if (is_div_q) begin
            res_lo = neg_q  ? -step[WIDTH-1:0]       : step[WIDTH-1:0];
            res_hi = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = prod_fix[WIDTH-1:0];
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end
`else
    logic unused_op0;
    assign unused_op0 = mif.op[0];
    assign mag_a  = mif.a;
    assign mag_b  = mif.b;
    assign res_lo = step[WIDTH-1:0];
    assign res_hi = step[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        m_d      = m_q;
        p_d      = p_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (mif.start) begin
                    is_div_d = mif.op[1];
                    if (mif.op[1] && (mif.b == '0)) begin
                        state_d = S_DONE;
                        hi_d    = mif.a;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CW'(WIDTH - 1);
                        m_d     = mif.op[1] ? mag_b : mag_a;
                        p_d     = {{WIDTH{1'b0}}, (mif.op[1] ? mag_a : mag_b)};
                    end
                end
            end
            S_RUN: begin
                p_d = step;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    dz_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            m_q      <= '0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            m_q      <= m_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign mif.busy = busy_q;
    assign mif.done = done_q;
    assign mif.dz   = dz_q;
    assign mif.hi   = hi_q;
    assign mif.lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu at WIDTH = 32; expectations follow MDU_SIGNED_EN when defined.
module tb_mdu;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mdu_if #(.WIDTH(W)) mif ();

    mdu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a request for one edge, then scramble operands to prove they were captured.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = op;
        mif.a     = a;
        mif.b     = b;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        mif.op    = ~op;
        mif.a     = 32'h5A5A_1234;
        mif.b     = 32'h0000_0003;
    endtask

    task automatic wait_done(output int n, output int nbusy);
        n     = 0;
        nbusy = 0;
        while (!mif.done && n < 200) begin
            if (mif.busy) nbusy++;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    int n, nb, dcount;

    initial begin
        mif.start = 1'b0;
        mif.op    = 2'b00;
        mif.a     = '0;
        mif.b     = '0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", mif.busy, 0);
        check("rst_done", mif.done, 0);
        check("rst_hi",   mif.hi,   0);
        check("rst_lo",   mif.lo,   0);
        check("rst_dz",   mif.dz,   0);
        reset = 1'b0;

        // multu max * max
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, nb);
        check("multu_lat",  n,  32);
        check("multu_busy", nb, 32);
        check("multu_busy_in_done", mif.busy, 0);
        check("multu_hi", mif.hi, 32'hFFFF_FFFE);
        check("multu_lo", mif.lo, 32'h0000_0001);
        check("multu_dz", mif.dz, 0);

        // mult -3 * 5; previous result must hold while running
        issue(2'b01, 32'hFFFF_FFFD, 32'd5);
        check("hold_hi", mif.hi, 32'hFFFF_FFFE);
        check("hold_done", mif.done, 0);
        wait_done(n, nb);
        check("mult_lat", n, 32);
`ifdef MDU_SIGNED_EN
        check("mult_hi", mif.hi, 32'hFFFF_FFFF);
`else
        check("mult_hi", mif.hi, 32'h0000_0004);
`endif
        check("mult_lo", mif.lo, 32'hFFFF_FFF1);

        // div -7 / 2, then most-negative / -1 launched from the DONE cycle
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(n, nb);
        check("div_lat", n, 32);
`ifdef MDU_SIGNED_EN
        check("div_lo", mif.lo, 32'hFFFF_FFFD);
        check("div_hi", mif.hi, 32'hFFFF_FFFF);
`else
        check("div_lo", mif.lo, 32'h7FFF_FFFC);
        check("div_hi", mif.hi, 32'h0000_0001);
`endif
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        check("b2b_busy", mif.busy, 1);
        wait_done(n, nb);
        check("b2b_lat", n, 32);
`ifdef MDU_SIGNED_EN
        check("ovf_lo", mif.lo, 32'h8000_0000);
        check("ovf_hi", mif.hi, 32'h0000_0000);
`else
        check("ovf_lo", mif.lo, 32'h0000_0000);
        check("ovf_hi", mif.hi, 32'h8000_0000);
`endif

        // divu by zero, then multu clears dz
        issue(2'b10, 32'd100, 32'd0);
        wait_done(n, nb);
        check("dz_lat",  n,  0);
        check("dz_busy", nb + int'(mif.busy), 0);
        check("dz_lo", mif.lo, 32'hFFFF_FFFF);
        check("dz_hi", mif.hi, 32'h0000_0064);
        check("dz_flag", mif.dz, 1);
        issue(2'b00, 32'd2, 32'd3);
        wait_done(n, nb);
        check("dzclr_flag", mif.dz, 0);
        check("dzclr_lo", mif.lo, 32'd6);
        check("dzclr_hi", mif.hi, 32'd0);

        // start during RUN is dropped
        issue(2'b00, 32'd7, 32'd9);
        repeat (4) @(posedge clk);
        issue(2'b00, 32'd1, 32'd1);
        wait_done(n, nb);
        check("ign_lat", n + 5, 32);
        check("ign_lo", mif.lo, 32'd63);
        check("ign_hi", mif.hi, 32'd0);
        @(posedge clk);
        #1;
        check("ign_noqueue_done", mif.done, 0);
        check("ign_noqueue_busy", mif.busy, 0);

        // reset mid divide aborts with no done pulse
        issue(2'b10, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", mif.busy, 0);
        check("abort_hi", mif.hi, 0);
        check("abort_lo", mif.lo, 0);
        check("abort_dz", mif.dz, 0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (mif.done || mif.busy) dcount++;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", dcount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
